// File: rtl/gearbox_pkg.sv
// Shared types and constants for the 64b/66b TX gearbox sequencer.
package gearbox_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned HEAD_W = 2;
  localparam int unsigned SEQ_N  = DATA_W / HEAD_W + 1;
  localparam int unsigned SEQ_W  = $clog2(SEQ_N);

  localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b10;
  localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b01;

  typedef struct packed {
    logic [HEAD_W-1:0] head;
    logic [DATA_W-1:0] data;
  } block_t;

  // Control block type 0x1E in byte 0 followed by eight idle codes (0x00).
  localparam block_t IDLE_BLOCK = '{head: SYNC_CTRL, data: DATA_W'(8'h1E)};

  localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(SEQ_N - 1);

  // The last slot of every sequence is left empty so the gearbox can flush.
  function automatic logic is_pause_slot(input logic [SEQ_W-1:0] seq);
    return seq == SEQ_LAST;
  endfunction

endpackage

// File: rtl/pcs_skid_buf.sv
// One-entry holding register for a block that arrives in the gearbox pause slot.
module pcs_skid_buf
  import gearbox_pkg::*;
(
  input  logic   clk,
  input  logic   nreset,
  input  logic   set,
  input  logic   clr,
  input  block_t din,
  output block_t dout,
  output logic   full
);

  block_t blk_q;
  logic   full_q;

  // Capture on set, release on clr; the caller never raises both together.
  always_ff @(posedge clk) begin
    if (nreset) begin
      blk_q  <= '0;
      full_q <= 1'b0;
    end else if (set) begin
      blk_q  <= din;
      full_q <= 1'b1;
    end else if (clr) begin
      full_q <= 1'b0;
    end
  end

  assign dout = blk_q;
  assign full = full_q;

endmodule

// File: rtl/gearbox_tx_ctrl.sv
// Sequencer in front of the 64b/66b TX gearbox: one block per slot on a free-running
// 33-slot sequence with the last slot left empty, a one-entry skid for the pause-slot
// transfer, underflow reporting and a sticky accept-violation flag.
// Build option: GEARBOX_TX_CTRL_IDLE_FILL_EN sends IDLE_BLOCK in starved loading slots.
module gearbox_tx_ctrl
  import gearbox_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  input  logic              gb_accept_i,
  output logic              gb_v_o,
  output logic [HEAD_W-1:0] gb_head_o,
  output logic [DATA_W-1:0] gb_data_o,
  output logic [SEQ_W-1:0]  gb_seq_o,
  output logic              underflow_o,
  output logic              err_o
);

  logic [SEQ_W-1:0] seq_q;
  logic             pause;
  logic             xfer;

  block_t skid_blk;
  logic   full_q;
  logic   skid_set;
  logic   skid_clr;

  logic              gb_v_q;
  logic              gb_v_d;
  block_t            gb_blk_q;
  block_t            gb_blk_d;
  logic [SEQ_W-1:0]  gb_seq_q;
  logic              underflow_q;
  logic              underflow_d;
  logic              err_q;

  // ready depends only on registered state, never on valid_i.
  assign ready_o = ~full_q;
  assign xfer    = valid_i & ready_o;
  assign pause   = is_pause_slot(seq_q);

  pcs_skid_buf u_skid (
    .clk    (clk),
    .nreset (nreset),
    .set    (skid_set),
    .clr    (skid_clr),
    .din    ('{head: head_i, data: data_i}),
    .dout   (skid_blk),
    .full   (full_q)
  );

  // Free-running slot counter, wraps after the pause slot regardless of traffic.
  always_ff @(posedge clk) begin
    if (nreset) begin
      seq_q <= '0;
    end else if (pause) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_q + SEQ_W'(1);
    end
  end

  // Source selection: skid first, then upstream, then fill or underflow.
  always_comb begin
    skid_set    = 1'b0;
    skid_clr    = 1'b0;
    gb_v_d      = 1'b0;
    gb_blk_d    = gb_blk_q;
    underflow_d = 1'b0;
    if (pause) begin
      skid_set = xfer;
    end else if (full_q) begin
      skid_clr = 1'b1;
      gb_v_d   = 1'b1;
      gb_blk_d = skid_blk;
    end else if (xfer) begin
      gb_v_d   = 1'b1;
      gb_blk_d = '{head: head_i, data: data_i};
    end else begin
      underflow_d = 1'b1;
`ifdef GEARBOX_TX_CTRL_IDLE_FILL_EN
      gb_v_d   = 1'b1;
      gb_blk_d = IDLE_BLOCK;
`endif
    end
  end

  // Output register: one-cycle latency, slot index tagged with the source slot.
  always_ff @(posedge clk) begin
    if (nreset) begin
      gb_v_q      <= 1'b0;
      gb_blk_q    <= '0;
      gb_seq_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      gb_v_q      <= gb_v_d;
      gb_blk_q    <= gb_blk_d;
      gb_seq_q    <= seq_q;
      underflow_q <= underflow_d;
    end
  end

  // Sticky flag for a block presented while the gearbox was not accepting.
  always_ff @(posedge clk) begin
    if (nreset) begin
      err_q <= 1'b0;
    end else if (gb_v_q && !gb_accept_i) begin
      err_q <= 1'b1;
    end
  end

  assign gb_v_o      = gb_v_q;
  assign gb_head_o   = gb_blk_q.head;
  assign gb_data_o   = gb_blk_q.data;
  assign gb_seq_o    = gb_seq_q;
  assign underflow_o = underflow_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_gearbox_tx_ctrl.sv
// Randomized self-checking bench for gearbox_tx_ctrl against an in-order FIFO model.
module tb_gearbox_tx_ctrl;
  import gearbox_pkg::*;

  logic              clk = 1'b0;
  logic              nreset;
  logic              valid_i;
  logic [HEAD_W-1:0] head_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic              gb_accept_i;
  logic              gb_v_o;
  logic [HEAD_W-1:0] gb_head_o;
  logic [DATA_W-1:0] gb_data_o;
  logic [SEQ_W-1:0]  gb_seq_o;
  logic              underflow_o;
  logic              err_o;

  gearbox_tx_ctrl dut (
    .clk         (clk),
    .nreset      (nreset),
    .valid_i     (valid_i),
    .head_i      (head_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .gb_accept_i (gb_accept_i),
    .gb_v_o      (gb_v_o),
    .gb_head_o   (gb_head_o),
    .gb_data_o   (gb_data_o),
    .gb_seq_o    (gb_seq_o),
    .underflow_o (underflow_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: blocks leave in arrival order, one per non-pause slot.
  int          m_slot;
  logic [65:0] m_q[$];
  logic        e_v, e_uf, e_err;
  logic [1:0]  e_head;
  logic [63:0] e_data;
  int          e_seq;

  task automatic model_reset();
    m_slot = 0;
    m_q.delete();
    e_v = 1'b0; e_uf = 1'b0; e_err = 1'b0;
    e_head = '0; e_data = '0; e_seq = 0;
  endtask

  // Called at a falling edge: check registered outputs, drive inputs, advance model.
  task automatic run_cycle(input bit rst, input bit v, input logic [1:0] h,
                           input logic [63:0] d, input bit acc);
    logic        m_ready;
    logic [65:0] blk;
    check_eq("gb_v", 64'(gb_v_o), 64'(e_v));
    check_eq("gb_head", 64'(gb_head_o), 64'(e_head));
    check_eq("gb_data", gb_data_o, e_data);
    check_eq("gb_seq", 64'(gb_seq_o), 64'(e_seq));
    check_eq("underflow", 64'(underflow_o), 64'(e_uf));
    check_eq("err", 64'(err_o), 64'(e_err));
    nreset = rst; valid_i = v; head_i = h; data_i = d; gb_accept_i = acc;
    m_ready = (m_q.size() == 0);
    check_eq("ready", 64'(ready_o), 64'(m_ready));
    if (rst) begin
      model_reset();
    end else begin
      e_err = e_err | (e_v & ~acc);
      if (v && m_ready) m_q.push_back({h, d});
      e_seq = m_slot;
      e_v   = 1'b0;
      e_uf  = 1'b0;
      if (m_slot != SEQ_N - 1) begin
        if (m_q.size() > 0) begin
          blk = m_q.pop_front();
          e_v = 1'b1;
          {e_head, e_data} = blk;
        end else begin
          e_uf = 1'b1;
`ifdef GEARBOX_TX_CTRL_IDLE_FILL_EN
          e_v    = 1'b1;
          e_head = 2'b10;
          e_data = 64'h1E;
`endif
        end
      end
      m_slot = (m_slot + 1) % SEQ_N;
    end
    @(negedge clk);
  endtask

  task automatic idle_to_slot(input int s);
    while (m_slot != s) run_cycle(0, 0, 2'b00, 64'h0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Valid with unknown data while reset is held.
    nreset = 1'b1; valid_i = 1'b1; head_i = 'x; data_i = 'x; gb_accept_i = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();

    // Continuous traffic, data counting from 1.
    for (int i = 0; i < 66; i++) run_cycle(0, 1, SYNC_DATA, 64'(i + 1), 1);
    check_eq("no_x", 64'($isunknown({ready_o, gb_v_o, gb_head_o, gb_data_o, gb_seq_o,
                                     underflow_o, err_o})), 64'(0));

    // Single block in slot 5, then starve.
    run_cycle(1, 0, 2'b00, 64'h0, 1);
    idle_to_slot(5);
    run_cycle(0, 1, SYNC_DATA, 64'h55, 1);
    repeat (35) run_cycle(0, 0, 2'b00, 64'h0, 1);

    // Transfer exactly in the pause slot; next offer is held off one cycle.
    idle_to_slot(32);
    run_cycle(0, 1, SYNC_DATA, 64'hA5, 1);
    run_cycle(0, 1, SYNC_DATA, 64'hB6, 1);
    repeat (4) run_cycle(0, 0, 2'b00, 64'h0, 1);

    // Reset with the skid full, then reset colliding with a transfer in slot 17.
    idle_to_slot(32);
    run_cycle(0, 1, SYNC_DATA, 64'hC3, 1);
    run_cycle(1, 1, SYNC_DATA, 64'hC4, 1);
    run_cycle(0, 0, 2'b00, 64'h0, 1);
    while (m_slot != 17) run_cycle(0, 1, SYNC_DATA, {$urandom, $urandom}, 1);
    run_cycle(1, 1, SYNC_DATA, 64'hDEAD, 1);
    repeat (3) run_cycle(0, 1, SYNC_CTRL, {$urandom, $urandom}, 1);

    // Accept dropped while a block is presented; flag must stick until reset.
    while (m_slot != 10) run_cycle(0, 1, SYNC_DATA, {$urandom, $urandom}, 1);
    run_cycle(0, 1, SYNC_DATA, {$urandom, $urandom}, 0);
    repeat (40) run_cycle(0, 1, SYNC_DATA, {$urandom, $urandom}, 1);
    run_cycle(1, 0, 2'b00, 64'h0, 1);
    run_cycle(0, 0, 2'b00, 64'h0, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      run_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                2'($urandom), {$urandom, $urandom}, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
